// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with registered (non-fall-through) read port.
// Pointers carry an extra wrap bit so full and empty come straight from pointer compare.
module sync_byte_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr, r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  w_wa, w_ra;

  // Flags depend only on registered pointers, never on the request inputs.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                 (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
  assign dout  = r_dout;

  assign w_wa = wr_en & ~full;
  assign w_ra = rd_en & ~empty;

  // Storage is left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (w_wa) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_dout   <= '0;
    end else begin
      if (w_wa) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_ra) begin
        r_dout   <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_byte_fifo.sv
// Directed bench for sync_byte_fifo: reset, single byte, fill/overflow,
// streaming, underflow, pointer wrap and asynchronous reset mid-transfer.
module tb_sync_byte_fifo;

  logic       clk = 1'b0;
  logic       srst = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] dout;
  logic       full, empty;

  int n_checks = 0;
  int n_fail   = 0;

  sync_byte_fifo #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
    .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    srst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    cyc();
    srst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    srst = 1'b1;
    #1;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h exp 00", dout); end
    cyc();
    srst = 1'b0;
    cyc();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_release_empty got %b exp 1", empty); end
  endtask

  task automatic test_single();
    wr_en = 1'b1; din = 8'hA5;
    cyc();
    wr_en = 1'b0;
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty_fall got %b exp 0", empty); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL single_dout_before_read got %h exp 00", dout); end
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL single_dout got %h exp a5", dout); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty_again got %b exp 1", empty); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; din = 8'(i);
      cyc();
      n_checks++; if (full !== (i == 15)) begin n_fail++; $display("FAIL fill_full_%0d got %b exp %b", i, full, (i == 15)); end
      n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty_%0d got %b exp 0", i, empty); end
    end
    din = 8'hFF;
    cyc();
    wr_en = 1'b0;
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL overflow_full got %b exp 1", full); end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      cyc();
      n_checks++; if (dout !== 8'(i)) begin n_fail++; $display("FAIL fill_read_%0d got %h exp %h", i, dout, 8'(i)); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL fill_read_full_%0d got %b exp 0", i, full); end
    end
    rd_en = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_drained_empty got %b exp 1", empty); end
    // A 17th entry would have been read here if the FF write had been taken.
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    n_checks++; if (dout !== 8'h0F) begin n_fail++; $display("FAIL overflow_not_stored got %h exp 0f", dout); end
  endtask

  task automatic test_stream();
    logic [7:0] d [16];
    do_reset();
    for (int e = 0; e < 16; e++) begin
      d[e] = 8'($urandom_range(0, 255));
      wr_en = 1'b1; rd_en = 1'b1; din = d[e];
      cyc();
      if (e == 0) begin
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL stream_first_dout got %h exp 00", dout); end
      end else begin
        n_checks++; if (dout !== d[e-1]) begin n_fail++; $display("FAIL stream_dout_%0d got %h exp %h", e, dout, d[e-1]); end
      end
      n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL stream_empty_%0d got %b exp 0", e, empty); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL stream_full_%0d got %b exp 0", e, full); end
    end
    wr_en = 1'b0;
    cyc();
    rd_en = 1'b0;
    n_checks++; if (dout !== d[15]) begin n_fail++; $display("FAIL stream_last got %h exp %h", dout, d[15]); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL stream_drained got %b exp 1", empty); end
  endtask

  task automatic test_underflow();
    logic [7:0] held;
    held = dout;
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (dout !== held) begin n_fail++; $display("FAIL underflow_dout_%0d got %h exp %h", i, dout, held); end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL underflow_empty_%0d got %b exp 1", i, empty); end
    end
    rd_en = 1'b0;
    wr_en = 1'b1; din = 8'h3C;
    cyc();
    wr_en = 1'b0; rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    n_checks++; if (dout !== 8'h3C) begin n_fail++; $display("FAIL underflow_recover got %h exp 3c", dout); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL underflow_recover_empty got %b exp 1", empty); end
  endtask

  task automatic test_wrap_and_async_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; din = 8'h80 + 8'(i);
      cyc();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd_en = 1'b1;
      cyc();
    end
    rd_en = 1'b0;
    n_checks++; if (dout !== 8'h89) begin n_fail++; $display("FAIL wrap_first_batch got %h exp 89", dout); end
    for (int i = 0; i < 12; i++) begin
      wr_en = 1'b1; din = 8'hC0 + 8'(i);
      cyc();
    end
    wr_en = 1'b0;
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL wrap_full got %b exp 0", full); end
    for (int i = 0; i < 12; i++) begin
      rd_en = 1'b1;
      cyc();
      n_checks++; if (dout !== 8'hC0 + 8'(i)) begin n_fail++; $display("FAIL wrap_read_%0d got %h exp %h", i, dout, 8'hC0 + 8'(i)); end
    end
    rd_en = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b exp 1", empty); end
    // Queue some data, then hit reset in the middle of a write cycle.
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; din = 8'h11 * 8'(i + 1);
      cyc();
    end
    din = 8'h44;
    #2;
    srst = 1'b1;
    #1;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL async_rst_empty got %b exp 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL async_rst_full got %b exp 0", full); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL async_rst_dout got %h exp 00", dout); end
    wr_en = 1'b0;
    #1;
    srst = 1'b0;
    cyc();
    wr_en = 1'b1; din = 8'h5A;
    cyc();
    wr_en = 1'b0; rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    n_checks++; if (dout !== 8'h5A) begin n_fail++; $display("FAIL post_rst_read got %h exp 5a", dout); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL post_rst_empty got %b exp 1", empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_underflow();
    test_wrap_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Flags must be mutually exclusive at every sampling point.
  always @(negedge clk) begin
    if (empty === 1'b1 && full === 1'b1) begin
      n_fail++;
      $display("FAIL flags_exclusive got empty=%b full=%b exp not both 1", empty, full);
    end
  end

endmodule
